// File: rtl/pulse_stretch_queue.sv
// -----------------------------------------------------------------------------
// pulse_stretch_queue
//
// Regenerates single-cycle event strobes as fixed-width level pulses with a
// guaranteed low gap between them, so level-sampled consumers (LEDs, slow
// logic) observe every event. Events that arrive while a pulse is playing are
// counted and replayed in order. Events beyond the queue depth are dropped and
// flagged with a sticky overflow bit.
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   rst       in   asynchronous, active-high reset
//   trig      in   event strobe; every high cycle is one event
//   clr_ovf   in   synchronous clear of the overflow flag (a same-cycle set wins)
//   out       out  stretched pulse, high for HIGH_CYCLES per event (registered)
//   busy      out  high while a pulse or its trailing gap is playing (registered)
//   pending   out  number of queued events not yet started (registered)
//   overflow  out  sticky: an event was dropped because the queue was full
// -----------------------------------------------------------------------------
module pulse_stretch_queue #(
  parameter int HIGH_CYCLES = 4,  // cycles out stays high per event (>= 1)
  parameter int GAP_CYCLES  = 2,  // minimum low cycles between events (>= 1)
  parameter int MAX_PEND    = 3,  // queue depth beyond the playing event (>= 1)
  parameter int PW          = 2   // pending width, 2**PW > MAX_PEND
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic          clr_ovf,
  output logic          out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  // The counter only ever holds a reload value minus one, so it needs enough
  // bits for max(HIGH_CYCLES, GAP_CYCLES) - 1 (at least one bit).
  localparam int MAX_CNT = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP
  } state_e;

  state_e          state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic [PW-1:0]   pending_q,  pending_d;
  logic            overflow_q, overflow_d;
  logic            out_q,      out_d;
  logic            busy_q,     busy_d;

  // Event bookkeeping for the current cycle.
  logic take_pend;   // a queued event starts playing at the end of this GAP
  logic queue_evt;   // trig must be added to the queue (not consumed directly)
  logic drop_evt;    // queue_evt with no room left

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    take_pend  = 1'b0;
    queue_evt  = 1'b0;
    drop_evt   = 1'b0;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      ST_HIGH: begin
        queue_evt = trig;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CW'(1);
          queue_evt = trig;
        end else if (pending_q != '0) begin
          // Oldest queued event starts now; a simultaneous trig joins the
          // queue in the slot that was just freed.
          state_d   = ST_HIGH;
          cnt_d     = HIGH_LOAD;
          take_pend = 1'b1;
          queue_evt = trig;
        end else if (trig) begin
          // Empty queue: the new event is played directly, never queued.
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A dequeue in the same cycle makes room, so a full queue only drops the
    // event when nothing is leaving it.
    drop_evt = queue_evt && !take_pend && (pending_q == PEND_MAX);

    unique case ({take_pend, queue_evt && !drop_evt})
      2'b10:   pending_d = pending_q - PW'(1);
      2'b01:   pending_d = pending_q + PW'(1);
      default: pending_d = pending_q;
    endcase

    // Set has priority over clear.
    if (drop_evt) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    // Outputs are decoded from the next state so they leave a flop directly.
    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretch_queue.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_queue
//
// Self-checking bench for pulse_stretch_queue with default parameters.
// Directed vector tables cover the single-event and three-event timelines,
// hand-written sequences cover saturation, gap-end hand-off, asynchronous
// reset and overflow set/clear priority, and a random phase compares every
// output against a timeline model built from pulse start times.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_queue;

  localparam int H   = 4;
  localparam int G   = 2;
  localparam int MAXP = 3;
  localparam int PW  = 2;

  logic          clk;
  logic          rst;
  logic          trig;
  logic          clr_ovf;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int tests;
  int fails;

  // Timeline model: the visible start cycle of the most recent pulse plus the
  // queue count. A pulse started at s is high for cycles s..s+H-1 and keeps
  // the block busy until s+H+G-1.
  int m_t;
  int m_s;
  int m_pend;
  int m_ovf;

  pulse_stretch_queue #(
    .HIGH_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PEND    (MAXP),
    .PW          (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .clr_ovf  (clr_ovf),
    .out      (out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance the model by one sampled cycle (inputs seen during cycle m_t).
  task automatic model_step(input logic t, input logic c);
    int  last_gap;
    logic set;
    last_gap = m_s + H + G - 1;
    set      = 1'b0;
    if (m_t > last_gap) begin
      if (t) m_s = m_t + 1;
    end else if (m_t == last_gap) begin
      if (m_pend > 0) begin
        m_s = m_t + 1;
        m_pend--;
        if (t) m_pend++;
      end else if (t) begin
        m_s = m_t + 1;
      end
    end else if (t) begin
      if (m_pend < MAXP) m_pend++;
      else begin
        m_ovf = 1;
        set   = 1'b1;
      end
    end
    if (c && !set) m_ovf = 0;
    m_t++;
  endtask

  // Apply inputs for one cycle, advance past the edge, land #1 after it.
  task automatic step(input logic t, input logic c);
    trig    = t;
    clr_ovf = c;
    model_step(t, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trig    = 1'b0;
    clr_ovf = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_t    = 0;
    m_s    = -1000;
    m_pend = 0;
    m_ovf  = 0;
  endtask

  typedef struct {
    logic pre_rst;
    logic trig;
    logic clr;
    logic e_out;
    logic e_busy;
    int   e_pend;
    logic e_ovf;
  } vec_t;

  vec_t vecs[26];

  initial begin
    int windows;
    logic prev_out;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    trig  = 1'b0;
    clr_ovf = 1'b0;

    // Row k: inputs during cycle k, expected outputs during cycle k+1.
    // Single event at cycle 0.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    // Events at cycles 0, 1, 2: windows at 1-4, 7-10, 13-16.
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};

    // Reset state.
    do_reset();
    check("reset.out",      out,      0);
    check("reset.busy",     busy,     0);
    check("reset.pending",  pending,  0);
    check("reset.overflow", overflow, 0);

    // Directed tables.
    for (int i = 0; i < 26; i++) begin
      if (vecs[i].pre_rst) do_reset();
      step(vecs[i].trig, vecs[i].clr);
      check($sformatf("vec%0d.out", i),      out,      vecs[i].e_out);
      check($sformatf("vec%0d.busy", i),     busy,     vecs[i].e_busy);
      check($sformatf("vec%0d.pending", i),  pending,  vecs[i].e_pend);
      check($sformatf("vec%0d.overflow", i), overflow, vecs[i].e_ovf);
    end

    // trig held for 6 cycles: queue saturates, 4 windows, clr at cycle 30.
    do_reset();
    windows  = 0;
    prev_out = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(c < 6, 1'b0);
      if (out && !prev_out) windows++;
      prev_out = out;
      if (c == 4) begin
        check("hold.ovf_c5",  overflow, 1);
        check("hold.pend_c5", pending,  3);
      end
    end
    check("hold.windows",     windows,  4);
    check("hold.ovf_before",  overflow, 1);
    step(1'b0, 1'b1);
    check("hold.ovf_cleared", overflow, 0);
    check("hold.idle",        busy,     0);

    // trig on the last GAP cycle with an empty queue.
    do_reset();
    step(1'b1, 1'b0);
    for (int c = 1; c < 6; c++) step(1'b0, 1'b0);
    check("gapend0.busy_c6", busy, 1);
    check("gapend0.out_c6",  out,  0);
    step(1'b1, 1'b0);
    check("gapend0.out_c7",  out,     1);
    check("gapend0.pend_c7", pending, 0);

    // Same with a full queue: net pending unchanged, no overflow.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("gapend3.pend_c6", pending, 3);
    step(1'b1, 1'b0);
    check("gapend3.out_c7",  out,      1);
    check("gapend3.pend_c7", pending,  3);
    check("gapend3.ovf_c7",  overflow, 0);

    // Asynchronous reset mid-HIGH with two events queued.
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
    check("arst.out_before",  out,     1);
    check("arst.pend_before", pending, 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst.out",      out,      0);
    check("arst.busy",     busy,     0);
    check("arst.pending",  pending,  0);
    check("arst.overflow", overflow, 0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0);
      check($sformatf("arst.stale_out%0d", c),  out,  0);
      check($sformatf("arst.stale_busy%0d", c), busy, 0);
    end

    // Overflowing trig with clr_ovf in the same cycle: set wins.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
    check("setwin.pend_c4", pending, 3);
    step(1'b1, 1'b1);
    check("setwin.ovf_set", overflow, 1);
    step(1'b0, 1'b1);
    check("setwin.ovf_clr", overflow, 0);

    // Random stimulus against the timeline model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4);
      check($sformatf("rnd%0d.out", i),
            out,      (m_t >= m_s && m_t <= m_s + H - 1) ? 1 : 0);
      check($sformatf("rnd%0d.busy", i),
            busy,     (m_t <= m_s + H + G - 1) ? 1 : 0);
      check($sformatf("rnd%0d.pending", i),  pending,  m_pend);
      check($sformatf("rnd%0d.overflow", i), overflow, m_ovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_queue.md
Name: pulse_stretch_queue

Overview:
Inverse companion of the button edge detector. Takes single-cycle event pulses (e.g. button rising-edge strobes or display-update strobes) and regenerates each one as a visible fixed-width level pulse with a guaranteed low gap, so LED or downstream level-sampled logic sees every event. Events arriving while a pulse is being played out are counted and replayed in order; excess events are flagged.

Parameters:
HIGH_CYCLES, 4, cycles out stays high per event (must be >= 1)
GAP_CYCLES, 2, minimum cycles out stays low between consecutive replayed events (must be >= 1)
MAX_PEND, 3, maximum queued events beyond the one currently playing (must be >= 1)
PW, 2, width of pending count; must satisfy 2^PW > MAX_PEND

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
trig  input  1  event strobe, synchronous to clk; each high cycle is one event
clr_ovf  input  1  synchronous clear of the overflow flag
out  output  1  stretched pulse output (registered)
busy  output  1  high whenever state is not IDLE (registered)
pending  output  PW  number of queued, not yet started events (registered)
overflow  output  1  sticky: an event was dropped because the queue was full

Behaviour:
- Reset (async, rst=1): state=IDLE, out=0, busy=0, pending=0, overflow=0, internal counter=0. Reset mid-pulse aborts immediately; queued events are discarded.
- States: IDLE, HIGH, GAP. out=1 only in HIGH. busy=1 in HIGH and GAP.
- Internal down-counter cnt, width sufficient for max(HIGH_CYCLES, GAP_CYCLES).
- IDLE: trig=1 -> HIGH, cnt=HIGH_CYCLES-1. Latency: out rises on the clock edge that samples trig, i.e. visible the cycle after trig.
- HIGH: cnt>0 -> cnt-1; cnt==0 -> GAP, cnt=GAP_CYCLES-1. out is high for exactly HIGH_CYCLES cycles.
- GAP: cnt>0 -> cnt-1. When cnt==0:
  - pending>0 -> HIGH, cnt=HIGH_CYCLES-1, and pending decremented by 1.
  - pending==0 and trig=1 -> HIGH directly, pending stays 0 (the event is consumed, not queued).
  - otherwise -> IDLE.
- Queueing: trig=1 in HIGH or GAP, except the consume case above, increments pending if pending<MAX_PEND. If pending==MAX_PEND, the event is dropped and overflow is set.
- Simultaneous trig and pending decrement at GAP end: net pending unchanged (one consumed, one queued). If pending==MAX_PEND at that moment, the new event fits; no overflow.
- overflow: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf=1 clears it. It is never cleared by state changes.
- Back-to-back events: period per replayed event = HIGH_CYCLES+GAP_CYCLES cycles. out never goes high for fewer than HIGH_CYCLES cycles or low for fewer than GAP_CYCLES cycles between events.
- trig held high N cycles = N events, subject to the queue limit.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset then single trig pulse at cycle 0 (defaults) -> out=1 cycles 1-4, low cycles 5-6 with busy=1, busy=0 from cycle 7, pending stays 0.
- Three trig pulses at cycles 0, 1, 2 -> pending goes 1, 2. Out produces 3 high windows: cycles 1-4, 7-10, 13-16, each separated by 2 low cycles. Pending reaches 0 at cycle 13. No overflow.
- trig held high for 6 cycles from cycle 0 -> 1 playing, pending saturates at 3, overflow=1 by cycle 5. Exactly 4 high windows follow. clr_ovf at cycle 30 -> overflow=0.
- trig exactly on the last GAP cycle with pending=0 -> next cycle out=1 with no IDLE cycle and pending stays 0. Repeat with pending=3 -> pending stays 3, overflow stays 0.
- Assert rst asynchronously mid-HIGH with pending=2 -> out, busy, pending and overflow go 0 immediately without waiting for clk. After release, no stale pulses appear.
- Same cycle: overflowing trig and clr_ovf=1 -> overflow=1 (set wins). Next cycle: clr_ovf=1 with no trig -> overflow=0.
